// File: rtl/mixcolumn_seq.sv
// Sequential AES MixColumns engine, COLS_PER_CYCLE columns per clock over valid/ready handshakes.
// Define MIXCOL_INV_EN to compile in InvMixColumns, selected per block by in_inv.
module mixcolumn_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int         NCYC = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST = 2'(NCYC - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [127:0]   cap_q, cap_d;
    logic [127:0]   res_q, res_d;
    logic           inv_q, inv_d;
    logic [127:0]   cap_mix;
    logic [31:0]    col;
    logic           accept;
    int             ci;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

`ifdef MIXCOL_INV_EN
    // Multiply by a 4-bit constant as a sum of x, 2x, 4x, 8x.
    function automatic logic [7:0] mulk(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {mulk(a0, 4'hE) ^ mulk(a1, 4'hB) ^ mulk(a2, 4'hD) ^ mulk(a3, 4'h9),
                mulk(a0, 4'h9) ^ mulk(a1, 4'hE) ^ mulk(a2, 4'hB) ^ mulk(a3, 4'hD),
                mulk(a0, 4'hD) ^ mulk(a1, 4'h9) ^ mulk(a2, 4'hE) ^ mulk(a3, 4'hB),
                mulk(a0, 4'hB) ^ mulk(a1, 4'hD) ^ mulk(a2, 4'h9) ^ mulk(a3, 4'hE)};
    endfunction
`endif

    // Column units, steered by the counter; finished columns overwrite the capture copy.
    always_comb begin
        cap_mix = cap_q;
        ci      = 0;
        col     = 32'h0;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            ci  = int'(cnt_q) * COLS_PER_CYCLE + k;
            col = cap_q[127 - 32*ci -: 32];
`ifdef MIXCOL_INV_EN
            cap_mix[127 - 32*ci -: 32] = inv_q ? inv_col(col) : fwd_col(col);
`else
            cap_mix[127 - 32*ci -: 32] = fwd_col(col);
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        res_d   = res_q;
        inv_d   = inv_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: accept = in_valid;
            BUSY: begin
                cap_d = cap_mix;
                if (cnt_q == LAST) begin
                    res_d   = cap_mix;
                    cnt_d   = 2'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) accept = 1'b1;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            cap_d   = in_data;
            cnt_d   = 2'd0;
            state_d = BUSY;
`ifdef MIXCOL_INV_EN
            inv_d   = in_inv;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            res_q   <= 128'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

`ifdef MIXCOL_INV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inv_q <= 1'b0;
        else        inv_q <= inv_d;
    end
`else
    assign inv_q = 1'b0;
    logic unused_inv;
    assign unused_inv = in_inv | inv_d;
`endif

    // Capture copy is pure data; its contents are meaningless outside BUSY.
    always_ff @(posedge clk) begin
        cap_q <= cap_d;
    end

    assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign out_data  = res_q;

endmodule

// File: tb/tb_mixcolumn_seq.sv
// Bench for mixcolumn_seq: three instances (1, 2, 4 columns/cycle) checked against a GF(2^8) matrix model.
module tb_mixcolumn_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   in_valid = '0;
    logic [2:0]   in_ready;
    logic [2:0]   in_inv = '0;
    logic [2:0]   out_valid;
    logic [2:0]   out_ready = '0;
    logic [2:0]   busy;
    logic [127:0] in_data  [3];
    logic [127:0] out_data [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mixcolumn_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .in_inv    (in_inv[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h11B << (i - 8);
        return p[7:0];
    endfunction

    // Circulant matrix product; inverse only exists when the feature is compiled in.
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   row0 [4];
        logic [127:0] r = '0;
        logic [7:0]   acc;
        logic         eff = inv;
`ifndef MIXCOL_INV_EN
        eff = 1'b0;
`endif
        if (eff) row0 = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
        else     row0 = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) begin
                acc = 8'h0;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(row0[(j - rr + 4) % 4], s[127 - 32*c - 8*j -: 8]);
                r[127 - 32*c - 8*rr -: 8] = acc;
            end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_ready(input int d);
        bit ok = 0;
        @(negedge clk);
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready[d]) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL ready_timeout dut=%0d in_ready never rose, required 1", d);
        end
    endtask

    // Called #1 after the accept edge: counts edges to out_valid, checks data, completes the output handshake.
    task automatic wait_result(input int d, input logic [127:0] exp, input string nm);
        int lat = 0;
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            n_checks++;
            if (busy[d] !== 1'b1 || out_valid[d] !== 1'b0 || in_ready[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_busy dut=%0d busy=%b out_valid=%b in_ready=%b, required 1 0 0",
                         nm, d, busy[d], out_valid[d], in_ready[d]);
            end
            @(posedge clk); #1;
            lat++;
            if (out_valid[d] === 1'b1) got = 1;
        end
        n_checks++;
        if (!got || lat != (4 >> d)) begin
            n_fail++;
            $display("FAIL %s_latency dut=%0d got %0d (valid=%b), required %0d", nm, d, lat, got, 4 >> d);
        end
        n_checks++;
        if (out_data[d] !== exp) begin
            n_fail++;
            $display("FAIL %s_data dut=%0d got %h, required %h", nm, d, out_data[d], exp);
        end
        @(negedge clk);
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        n_checks++;
        if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release dut=%0d out_valid=%b busy=%b, required 0 0", nm, d, out_valid[d], busy[d]);
        end
    endtask

    task automatic run_block(input int d, input logic [127:0] data, input logic inv,
                             input logic [127:0] exp, input string nm);
        wait_ready(d);
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_inv[d]   = inv;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        in_data[d]  = rnd128();
        in_inv[d]   = ~inv;
        wait_result(d, exp, nm);
    endtask

    task automatic test_reset;
        #1;
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (in_ready[d] !== 1'b0 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || out_data[d] !== 128'h0) begin
                n_fail++;
                $display("FAIL reset_state dut=%0d rdy=%b vld=%b busy=%b data=%h, required 0 0 0 0",
                         d, in_ready[d], out_valid[d], busy[d], out_data[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (in_ready[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_release dut=%0d in_ready=%b, required 1", d, in_ready[d]);
            end
        end
    endtask

    task automatic test_vectors;
        logic [127:0] exp_inv;
        logic [127:0] exp_fwd_inv1;
`ifdef MIXCOL_INV_EN
        exp_inv      = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        exp_fwd_inv1 = ref_mix(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b1);
`else
        exp_inv      = ref_mix(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0);
        exp_fwd_inv1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
`endif
        run_block(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                  128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, "vec_fwd");
        run_block(0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, exp_inv, "vec_inv");
        run_block(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b1, exp_fwd_inv1, "vec_mode1");
    endtask

    task automatic test_sweep;
        for (int d = 0; d < 3; d++)
            run_block(d, 128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0,
                      128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, "sweep");
    endtask

    task automatic test_random;
        logic [127:0] s;
        logic         inv;
        for (int d = 0; d < 3; d++)
            for (int n = 0; n < 8; n++) begin
                s   = rnd128();
                inv = 1'($urandom_range(0, 1));
                run_block(d, s, inv, ref_mix(s, inv), "random");
            end
    endtask

    task automatic test_backpressure;
        logic [127:0] a = rnd128();
        logic [127:0] b = rnd128();
        logic [127:0] hold;
        bit ok = 0;
        wait_ready(0);
        in_valid[0] = 1'b1; in_data[0] = a; in_inv[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (out_valid[0]) ok = 1;
            else begin @(posedge clk); #1; end
        end
        hold = out_data[0];
        n_checks++;
        if (!ok || hold !== ref_mix(a, 1'b0)) begin
            n_fail++;
            $display("FAIL bp_first dut=0 valid=%b got %h, required %h", ok, hold, ref_mix(a, 1'b0));
        end
        in_valid[0] = 1'b1; in_data[0] = rnd128(); in_inv[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || busy[0] !== 1'b0 || out_data[0] !== hold) begin
                n_fail++;
                $display("FAIL bp_hold cycle=%0d vld=%b rdy=%b busy=%b data=%h, required 1 0 0 %h",
                         i, out_valid[0], in_ready[0], busy[0], out_data[0], hold);
            end
        end
        @(negedge clk);
        in_data[0] = b;
        out_ready[0] = 1'b1;
        #1;
        n_checks++;
        if (in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_in_ready got %b, required 1", in_ready[0]);
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0; out_ready[0] = 1'b0; in_data[0] = rnd128();
        wait_result(0, ref_mix(b, 1'b0), "bp_second");
    endtask

    task automatic test_back_to_back;
        logic [127:0] q[$];
        logic [127:0] s;
        logic [127:0] exp;
        int sent = 0, got = 0, last = 0;
        out_ready[1] = 1'b1;
        in_inv[1]    = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            @(negedge clk);
            if (in_ready[1] && sent < 4) begin
                s = rnd128();
                in_valid[1] = 1'b1; in_data[1] = s;
                q.push_back(ref_mix(s, 1'b0));
                sent++;
            end else in_valid[1] = 1'b0;
            @(posedge clk); #1;
            if (out_valid[1]) begin
                exp = (q.size() > 0) ? q.pop_front() : 128'hx;
                n_checks++;
                if (out_data[1] !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_data blk=%0d got %h, required %h", got, out_data[1], exp);
                end
                if (got > 0) begin
                    n_checks++;
                    if (cyc - last != 3) begin
                        n_fail++;
                        $display("FAIL b2b_period blk=%0d got %0d, required 3", got, cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
        end
        in_valid[1] = 1'b0; out_ready[1] = 1'b0;
        n_checks++;
        if (got != 4) begin
            n_fail++;
            $display("FAIL b2b_count got %0d, required 4", got);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [127:0] s = rnd128();
        wait_ready(0);
        in_valid[0] = 1'b1; in_data[0] = s; in_inv[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || out_data[0] !== 128'h0 || in_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state vld=%b busy=%b data=%h rdy=%b, required 0 0 0 0",
                     out_valid[0], busy[0], out_data[0], in_ready[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        s = rnd128();
        run_block(0, s, 1'b0, ref_mix(s, 1'b0), "midreset_after");
    endtask

    initial begin
        for (int d = 0; d < 3; d++) in_data[d] = '0;
        test_reset();
        test_vectors();
        test_sweep();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
